sc_regen_multi: RTL and testbench



---
 rtl/sc_regen_multi_if.sv | 32 +++
 rtl/sc_regen_multi.sv | 111 +++++++++++
 tb/tb_sc_regen_multi.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sc_regen_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : sc_regen_multi_if
// Brief    : Sample/regenerated-bit bus for the stochastic bitstream regenerator.
//            count_out exists only when SC_REGEN_COUNT_OUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface sc_regen_multi_if #(
   parameter int WIDTH    = 5,
   parameter int CHANNELS = 2
);
   logic                  in_valid;
   logic [CHANNELS-1:0]   in_bits;
   logic                  mode;
   logic [CHANNELS-1:0]   out_bits;
   logic                  out_valid;
   logic                  window_done;
`ifdef SC_REGEN_COUNT_OUT_EN
   logic [CHANNELS*(WIDTH+1)-1:0] count_out;

   modport master (output in_valid, in_bits, mode,
                   input  out_bits, out_valid, window_done, count_out);
   modport slave  (input  in_valid, in_bits, mode,
                   output out_bits, out_valid, window_done, count_out);
`else
   modport master (output in_valid, in_bits, mode,
                   input  out_bits, out_valid, window_done);
   modport slave  (input  in_valid, in_bits, mode,
                   output out_bits, out_valid, window_done);
`endif
endinterface
`default_nettype wire

// File: rtl/sc_regen_multi.sv
`default_nettype none
// ============================================================================
// Module   : sc_regen_multi
// Brief    : Multi-channel stochastic bitstream regenerator. Counts ones per
//            2^WIDTH-sample window and re-emits that count in the next window
//            ordered by a bit-reversed (optionally per-channel rotated) phase.
//            Optional count_out port: define SC_REGEN_COUNT_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sc_regen_multi #(
   parameter int WIDTH    = 5,
   parameter int CHANNELS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   sc_regen_multi_if.slave       bus
);
   localparam int               c_CNT_W = WIDTH + 1;
   localparam logic [WIDTH-1:0] c_LAST  = '1;

   logic [WIDTH-1:0]    r_phase;
   logic [c_CNT_W-1:0]  r_acc  [CHANNELS];
   logic [c_CNT_W-1:0]  r_held [CHANNELS];
   logic                r_mode_q;
   logic                r_primed;
   logic [CHANNELS-1:0] r_out_bits;
   logic                r_out_valid;
   logic                r_window_done;

   logic [WIDTH-1:0]    w_rev;
   logic [CHANNELS-1:0] w_hit;

   always_comb begin
      w_rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_rev[i] = r_phase[WIDTH-1-i];
      end
   end

   // Rotation amount is a per-channel constant, so each channel gets fixed wiring.
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      localparam int c_ROT = k % WIDTH;
      logic [WIDTH-1:0] w_rot;
      logic [WIDTH-1:0] w_seq;

      if (c_ROT == 0) begin : g_norot
         assign w_rot = w_rev;
      end else begin : g_rot
         assign w_rot = {w_rev[WIDTH-1-c_ROT:0], w_rev[WIDTH-1:WIDTH-c_ROT]};
      end

      assign w_seq    = r_mode_q ? w_rot : w_rev;
      assign w_hit[k] = {1'b0, w_seq} < r_held[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase       <= '0;
         r_mode_q      <= 1'b0;
         r_primed      <= 1'b0;
         r_out_bits    <= '0;
         r_out_valid   <= 1'b0;
         r_window_done <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            r_acc[k]  <= '0;
            r_held[k] <= '0;
         end
      end else begin
         r_window_done <= 1'b0;
         r_out_valid   <= 1'b0;
         if (bus.in_valid) begin
            r_phase     <= r_phase + WIDTH'(1);
            r_out_valid <= r_primed;
            r_out_bits  <= w_hit & {CHANNELS{r_primed}};
            if (r_phase == c_LAST) begin
               // Last sample of the window: fold it straight into the held count.
               for (int k = 0; k < CHANNELS; k++) begin
                  r_held[k] <= r_acc[k] + c_CNT_W'(bus.in_bits[k]);
                  r_acc[k]  <= '0;
               end
               r_mode_q      <= bus.mode;
               r_primed      <= 1'b1;
               r_window_done <= 1'b1;
            end else begin
               for (int k = 0; k < CHANNELS; k++) begin
                  r_acc[k] <= r_acc[k] + c_CNT_W'(bus.in_bits[k]);
               end
            end
         end
      end
   end

   assign bus.out_bits    = r_out_bits;
   assign bus.out_valid   = r_out_valid;
   assign bus.window_done = r_window_done;

`ifdef SC_REGEN_COUNT_OUT_EN
   logic [CHANNELS*c_CNT_W-1:0] w_count;

   always_comb begin
      w_count = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         w_count[k*c_CNT_W +: c_CNT_W] = r_held[k];
      end
   end

   assign bus.count_out = w_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sc_regen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_regen_multi
// Brief    : Self-checking bench for sc_regen_multi (WIDTH=3, CHANNELS=2) with
//            directed windows followed by randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_regen_multi;
   localparam int WIDTH    = 3;
   localparam int CHANNELS = 2;
   localparam int WIN      = 8;

   logic clk;
   logic rst;

   sc_regen_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus_if ();

   sc_regen_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fails;

   // Window-level model state
   int m_phase;
   int m_acc  [CHANNELS];
   int m_held [CHANNELS];
   int m_mode_q;
   int m_primed;
   int e_bits [CHANNELS];
   int e_valid;
   int e_done;
   int obs_ones [CHANNELS];
   logic [7:0] cap0, cap1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Low-discrepancy position of sample p for channel k, from plain arithmetic.
   function automatic int seq_of(input int p, input int k, input int mq);
      int r;
      int s;
      r = (p % 2) * 4 + ((p / 2) % 2) * 2 + (p / 4);
      if (mq != 0) begin
         s = k % WIDTH;
         r = ((r << s) | (r >> (WIDTH - s))) % WIN;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_mode_q = 0;
      m_primed = 0;
      e_valid  = 0;
      e_done   = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         m_acc[k]    = 0;
         m_held[k]   = 0;
         e_bits[k]   = 0;
         obs_ones[k] = 0;
      end
   endtask

   task automatic step(input bit v, input bit [CHANNELS-1:0] b, input bit md);
      int old_held [CHANNELS];
      int last;
      int was_primed;
      bus_if.in_valid = v;
      bus_if.in_bits  = b;
      bus_if.mode     = md;
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         e_done  = 0;
         e_valid = 0;
         last       = 0;
         was_primed = m_primed;
         for (int k = 0; k < CHANNELS; k++) old_held[k] = m_held[k];
         if (v) begin
            e_valid = m_primed;
            for (int k = 0; k < CHANNELS; k++)
               e_bits[k] = (m_primed != 0 && seq_of(m_phase, k, m_mode_q) < m_held[k]) ? 1 : 0;
            if (m_phase == WIN - 1) begin
               last = 1;
               for (int k = 0; k < CHANNELS; k++) begin
                  m_held[k] = m_acc[k] + int'(b[k]);
                  m_acc[k]  = 0;
               end
               m_mode_q = md;
               m_primed = 1;
               e_done   = 1;
            end else begin
               for (int k = 0; k < CHANNELS; k++) m_acc[k] += int'(b[k]);
            end
            m_phase = (m_phase + 1) % WIN;
         end
         if (bus_if.out_valid === 1'b1)
            for (int k = 0; k < CHANNELS; k++) obs_ones[k] += int'(bus_if.out_bits[k]);
         if (last != 0) begin
            if (was_primed != 0) begin
               check("window_ones_ch0", obs_ones[0], old_held[0]);
               check("window_ones_ch1", obs_ones[1], old_held[1]);
            end
            for (int k = 0; k < CHANNELS; k++) obs_ones[k] = 0;
         end
      end
      check("out_valid",   bus_if.out_valid,   e_valid);
      check("window_done", bus_if.window_done, e_done);
      check("out_bits0",   bus_if.out_bits[0], e_bits[0]);
      check("out_bits1",   bus_if.out_bits[1], e_bits[1]);
`ifdef SC_REGEN_COUNT_OUT_EN
      check("count_out", bus_if.count_out, {4'(m_held[1]), 4'(m_held[0])});
`endif
      if (v) begin
         cap0 = {cap0[6:0], bus_if.out_bits[0]};
         cap1 = {cap1[6:0], bus_if.out_bits[1]};
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      cap0 = '0;
      cap1 = '0;
      model_reset();
      bus_if.in_valid = 1'b0;
      bus_if.in_bits  = '0;
      bus_if.mode     = 1'b0;
      rst = 1'b1;
      step(1'b1, 2'b11, 1'b0);
      step(1'b0, 2'b00, 1'b0);
      rst = 1'b0;
      check("reset_out_valid", bus_if.out_valid, 0);
      check("reset_out_bits",  bus_if.out_bits, 0);

      // Window 1: ch0 all ones, ch1 none; window 2 replays that.
      for (int i = 0; i < WIN; i++) step(1'b1, 2'b01, 1'b0);
      for (int i = 0; i < WIN; i++) step(1'b1, 2'b00, 1'b0);
      check("s1_ch0_stream", cap0, 8'hFF);
      check("s1_ch1_stream", cap1, 8'h00);

      // Window 3: ch0 three ones, shared sequence.
      for (int i = 0; i < WIN; i++) step(1'b1, {1'b0, (i == 1 || i == 4 || i == 6)}, 1'b0);
      // Window 4: replay ch0=3; feed both channels 3 ones with mode=1.
      for (int i = 0; i < WIN; i++) step(1'b1, (i < 3) ? 2'b11 : 2'b00, 1'b1);
      check("s2_ch0_stream", cap0, 8'b10101000);
      // Window 5: rotated replay while mode toggles; feed 3 ones each, mode=0 at end.
      for (int i = 0; i < WIN; i++)
         step(1'b1, (i >= 5) ? 2'b11 : 2'b00, (i == WIN - 1) ? 1'b0 : 1'(i % 2));
      check("s3_ch0_stream", cap0, 8'b10101000);
      check("s3_ch1_stream", cap1, 8'b11001000);
      // Window 6: shared replay with a 3-cycle gap at phase 4.
      for (int i = 0; i < WIN; i++) begin
         if (i == 4) for (int g = 0; g < 3; g++) step(1'b0, 2'b11, 1'b0);
         step(1'b1, 2'b10, 1'b0);
      end
      check("s4_ch0_stream", cap0, 8'b10101000);
      check("s4_ch1_stream", cap1, 8'b10101000);

      // Window 7: reset at phase 5, then an unprimed window.
      for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 1'b0);
      rst = 1'b1;
      step(1'b1, 2'b11, 1'b0);
      rst = 1'b0;
      check("s5_rst_out_bits", bus_if.out_bits, 0);
      for (int i = 0; i < WIN; i++) step(1'b1, 2'b01, 1'b0);
      for (int i = 0; i < WIN; i++) step(1'b1, 2'b00, 1'b0);
      check("s5_ch0_after_rst", cap0, 8'hFF);

      // Randomized traffic, biased toward valid cycles with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom));
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
`default_nettype wire
